// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt sequencer.
// Provides the FSM state encoding, default vector layout and a vector address helper.
package int_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      ACK     = 2'd2,
      SERVICE = 2'd3
   } state_t;

   localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
   localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;
   localparam int          CAUSE_W        = 2;

   function automatic logic [31:0] vec_addr(input logic [31:0]        base,
                                            input logic [31:0]        stride,
                                            input logic [CAUSE_W-1:0] idx);
      return base + (32'(idx) * stride);
   endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Trap/acknowledge handshake between the interrupt sequencer and the core.
// master = sequencer side, slave = hazard/PC and controller side.
interface int_ctrl_if;
   import int_pkg::*;

   logic               i_irqEnable;
   logic               i_trapTaken;
   logic               i_mret;
   logic               o_trapReq;
   logic [31:0]        o_trapVec;
   logic [CAUSE_W-1:0] o_cause;
   logic               o_iack_n;
   logic               o_busy;

   modport master (
      input  i_irqEnable, i_trapTaken, i_mret,
      output o_trapReq, o_trapVec, o_cause, o_iack_n, o_busy
   );

   modport slave (
      output i_irqEnable, i_trapTaken, i_mret,
      input  o_trapReq, o_trapVec, o_cause, o_iack_n, o_busy
   );

endinterface

// File: rtl/int_sync.sv
// Per-line 2-flop synchroniser; pending is the synced level (2 cycles), or with INT_EDGE_EN
// a sticky falling-edge flag (3 cycles) cleared by clr. No backpressure.
module int_sync #(
   parameter int NUM_IRQ = 3
) (
   input  logic               clk,
   input  logic               reset_x,
   input  logic [NUM_IRQ-1:0] oint_n,
`ifdef INT_EDGE_EN
   input  logic [NUM_IRQ-1:0] clr,
`endif
   output logic [NUM_IRQ-1:0] pending
);

   logic [NUM_IRQ-1:0] meta;
   logic [NUM_IRQ-1:0] sync;

   // Lines idle high, so the flops reset to the inactive level.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         meta <= '1;
         sync <= '1;
      end else begin
         meta <= oint_n;
         sync <= meta;
      end
   end

`ifdef INT_EDGE_EN
   logic [NUM_IRQ-1:0] dly;
   logic [NUM_IRQ-1:0] sticky;

   // A fresh edge on the same cycle as clr is kept, so it is not lost.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         dly    <= '1;
         sticky <= '0;
      end else begin
         dly    <= sync;
         sticky <= (sticky & ~clr) | (dly & ~sync);
      end
   end

   assign pending = sticky;
`else
   assign pending = ~sync;
`endif

endmodule

// File: rtl/int_ctrl.sv
// Interrupt sequencer: sync + priority + REQ/ACK/SERVICE FSM (INT_EDGE_EN selects edge mode).
// Request 3 cycles after pin (4 in edge mode); o_trapReq held until i_trapTaken, new IRQs blocked until mret.
module int_ctrl
   import int_pkg::*;
#(
   parameter int          NUM_IRQ    = 3,
   parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
   parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
   parameter int          ACK_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset_x,
   input  logic [NUM_IRQ-1:0] i_oint_n,
   int_ctrl_if.master         bus
);

   state_t             state, state_nxt;
   logic [3:0]         cnt, cnt_nxt;
   logic               trap_req_nxt, iack_n_nxt;
   logic [31:0]        vec_nxt;
   logic [CAUSE_W-1:0] cause_nxt, sel;
   logic [NUM_IRQ-1:0] pending_raw, pending, served;

   int_sync #(.NUM_IRQ(NUM_IRQ)) u_sync (
      .clk     (clk),
      .reset_x (reset_x),
      .oint_n  (i_oint_n),
`ifdef INT_EDGE_EN
      .clr     ((state == REQ && bus.i_trapTaken) ? served : '0),
`endif
      .pending (pending_raw)
   );

   // The latched line stays masked until the FSM is back in IDLE.
   always_comb begin
      served = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         served[i] = (state != IDLE) && (bus.o_cause == CAUSE_W'(i));
      end
   end

   assign pending = pending_raw & ~served;

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (pending[i]) sel = CAUSE_W'(i);
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      trap_req_nxt = bus.o_trapReq;
      vec_nxt      = bus.o_trapVec;
      cause_nxt    = bus.o_cause;
      iack_n_nxt   = 1'b1;
      case (state)
         IDLE: begin
            if ((|pending) && bus.i_irqEnable) begin
               state_nxt    = REQ;
               trap_req_nxt = 1'b1;
               cause_nxt    = sel;
               vec_nxt      = vec_addr(VEC_BASE, VEC_STRIDE, sel);
            end
         end
         REQ: begin
            // A committed redirect beats a same-cycle enable drop.
            if (bus.i_trapTaken) begin
               state_nxt    = ACK;
               trap_req_nxt = 1'b0;
               cnt_nxt      = 4'(ACK_CYCLES - 1);
               iack_n_nxt   = 1'b0;
            end else if (!bus.i_irqEnable) begin
               state_nxt    = IDLE;
               trap_req_nxt = 1'b0;
            end
         end
         ACK: begin
            if (cnt == 4'd0) begin
               state_nxt = SERVICE;
            end else begin
               cnt_nxt    = cnt - 4'd1;
               iack_n_nxt = 1'b0;
            end
         end
         SERVICE: begin
            if (bus.i_mret) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.o_trapReq <= 1'b0;
         bus.o_trapVec <= '0;
         bus.o_cause   <= '0;
         bus.o_iack_n  <= 1'b1;
         bus.o_busy    <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bus.o_trapReq <= trap_req_nxt;
         bus.o_trapVec <= vec_nxt;
         bus.o_cause   <= cause_nxt;
         bus.o_iack_n  <= iack_n_nxt;
         bus.o_busy    <= (state_nxt != IDLE);
      end
   end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt sequencer for the pipelined core. It synchronises the three active-low external interrupt lines and prioritises them. It raises a trap request to the hazard/PC logic and holds it until the pipeline reports the redirect. It then drives the active-low interrupt acknowledge for a fixed pulse and blocks further interrupts until the handler executes mret.

Parameters:
NUM_IRQ, 3, number of external interrupt lines (index NUM_IRQ-1 = highest priority)
VEC_BASE, 32'h0000_0100, handler vector for line 0
VEC_STRIDE, 32'h0000_0010, byte distance between consecutive line vectors
ACK_CYCLES, 2, width of the acknowledge pulse in cycles (legal range 1..15)

Ports:
clk  in  1  core clock
reset_x  in  1  asynchronous reset, active-low
i_oint_n  in  NUM_IRQ  external interrupt lines, active-low, asynchronous to clk
i_irqEnable  in  1  global interrupt enable from controller; 0 masks new requests
i_trapTaken  in  1  single-cycle pulse from hazard/PC logic: trap redirect committed this cycle
i_mret  in  1  single-cycle pulse: mret retired in W stage
o_trapReq  out  1  registered request to flush pipeline and redirect PC
o_trapVec  out  32  handler address, valid while o_trapReq=1
o_cause  out  2  index of the line being served, valid from REQ through SERVICE
o_iack_n  out  1  interrupt acknowledge to the bus, active-low
o_busy  out  1  1 in every state except IDLE

Behaviour:
- Reset (reset_x=0, asynchronous): state=IDLE, pending=0, synchroniser flops=1. o_trapReq=0, o_trapVec=0, o_cause=0, o_iack_n=1, o_busy=0.
- Synchroniser: 2-flop per line on the inverted i_oint_n. Latency from pin to pending is 2 cycles.
- Level mode (default): pending[i] = synced level, recomputed every cycle. Exception: the line latched for service is masked until the FSM returns to IDLE.
- Priority: highest set pending index wins. A fixed combinational encoder selects sel.
- FSM states: IDLE, REQ, ACK, SERVICE. All outputs are registered.
- IDLE -> REQ when (pending != 0) and i_irqEnable. On this transition, latch o_cause=sel and o_trapVec = VEC_BASE + sel*VEC_STRIDE, computed at 32-bit width with the upper bits zero-extended. Assert o_trapReq.
- REQ: hold o_trapReq, o_cause and o_trapVec stable. A higher-priority line arriving during REQ does not change the latched selection.
  - On i_trapTaken=1: go to ACK, drop o_trapReq, load ack counter = ACK_CYCLES-1, drive o_iack_n=0.
  - If i_irqEnable=0 and i_trapTaken=0: withdraw to IDLE and drop o_trapReq.
  - If i_irqEnable=0 and i_trapTaken=1 in the same cycle: i_trapTaken wins and the FSM goes to ACK.
- ACK: o_iack_n=0 for exactly ACK_CYCLES cycles, with the counter decrementing. When the counter reaches 0, go to SERVICE with o_iack_n=1.
- SERVICE: wait for i_mret, then go to IDLE. o_cause is held. A re-request from the same or another line is not possible before the next cycle in IDLE.
- Ignored inputs:
  - i_trapTaken outside REQ.
  - i_mret outside SERVICE. In ACK, i_mret is ignored and not remembered.
- Line deassert: if the latched line deasserts during REQ/ACK/SERVICE, the sequence still completes.
- Reset mid-operation: immediate return to reset values. An in-flight acknowledge is truncated and o_iack_n returns to 1.

Optional Feature:
INT_EDGE_EN:
- Defined: each line is falling-edge triggered on the synchronised signal, which adds one extra edge-detect flop (3-cycle latency).
  - An edge sets a sticky pending bit.
  - The bit is cleared only on the ACK entry for that line.
  - Edges on other lines during service remain pending.
- Undefined: level mode as above, and the edge-detect flops are not instantiated.

Decomposition:
- Package int_pkg: state enum (IDLE=2'd0, REQ=2'd1, ACK=2'd2, SERVICE=2'd3), default VEC_BASE/VEC_STRIDE constants, cause width constant.
- Sub-module int_sync: per-line 2-flop synchroniser plus optional edge detector, parameterised by NUM_IRQ.
- Priority encoder and FSM stay in int_ctrl.

Test Plan:
- Level request: i_irqEnable=1, i_oint_n=3'b110 held. o_trapReq rises 3 cycles later with o_trapVec=32'h100 and o_cause=0. Pulse i_trapTaken. o_iack_n is low for exactly 2 cycles. Pulse i_mret in SERVICE. o_busy returns to 0.
- Priority: i_oint_n=3'b010 (lines 0 and 2 both active) -> o_cause=2, o_trapVec=32'h120. Dropping line 2 during REQ does not change the latched vector.
- Masking/withdraw: i_irqEnable=0 with a line active -> no request. Enable, then drop enable in REQ without i_trapTaken -> o_trapReq falls next cycle and the state is IDLE. Drop enable in the same cycle as i_trapTaken -> ACK is entered.
- Spurious handshakes: i_trapTaken in IDLE and i_mret in REQ/ACK -> no state change and o_iack_n stays 1.
- Reset mid-ACK: reset_x=0 during the first acknowledge cycle -> o_iack_n=1 and o_busy=0 asynchronously. After release with the line still low, a fresh request appears after the synchroniser latency.
- INT_EDGE_EN: a single 1-cycle low pulse on line 1 while SERVICE is active for line 0. After mret, a request with o_cause=1 and o_trapVec=32'h110 follows. Without the macro, the same pulse is lost.
